// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction-fetch stage sitting just after the PC register. It issues one
// instruction-memory read at a time, buffers returned words together with
// their addresses in a small FIFO toward decode, and pulses pc_step so the
// next-PC logic advances. A redirect flushes the buffer and drops any response
// still in flight.
//
// Parameters
//   ADDR_W   PC / instruction-memory address width
//   INSTR_W  instruction word width
//   DEPTH    prefetch buffer entries (power of two, >= 2)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   pc         current PC from the PC register
//   redirect   one-cycle branch/jump flush pulse
//   pc_step    one-cycle pulse: next-PC logic selects pc+1
//   mem_req    instruction-memory read request
//   mem_addr   read address, stable while mem_req is high
//   mem_ack    read complete, mem_rdata valid
//   mem_rdata  read data
//   out_valid  head buffer entry valid
//   out_ready  decode accepts the head entry
//   out_instr  head instruction (0 when empty)
//   out_pc     address of head instruction (0 when empty)
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc,
   input  logic               redirect,
   output logic               pc_step,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      STEP = 2'd2
   } state_e;

   state_e             state_q,    state_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic               mem_req_q,  mem_req_d;
   logic               pc_step_q,  pc_step_d;
   logic               discard_q,  discard_d;
   logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [CNT_W-1:0]   count_q,    count_d;

   logic [INSTR_W-1:0] buf_instr_q [DEPTH];
   logic [ADDR_W-1:0]  buf_pc_q    [DEPTH];

   logic push;
   logic pop;

   // A response is kept only if it was not flagged for discard earlier and no
   // redirect arrives on the ack edge itself. Flush beats push and pop.
   assign push = (state_q == WAIT) && mem_ack && !discard_q && !redirect;
   assign pop  = (count_q != '0) && out_ready && !redirect;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path through this
      // block leaves a signal unassigned and no latch is inferred.
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      discard_d  = discard_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      unique case (state_q)
         IDLE: begin
            // Issuing only when a slot is free reserves space for the reply.
            if ((count_q < CNT_W'(DEPTH)) && !redirect) begin
               mem_addr_d = pc;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (mem_ack) begin
               discard_d = 1'b0;
               state_d   = STEP;
            end else if (redirect) begin
               // The request cannot be withdrawn; let it finish and drop it.
               discard_d = 1'b1;
            end
         end
         STEP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (redirect) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end

      // Outputs are registered from the next-state view of the FSM.
      mem_req_d = (state_d == WAIT);
      pc_step_d = push;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
         pc_step_q  <= 1'b0;
         discard_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
         pc_step_q  <= pc_step_d;
         discard_q  <= discard_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // NOTE: buffer storage has no reset; count_q alone decides which entries
   // are meaningful, and empty reads are forced to zero below.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr_q[wr_ptr_q] <= mem_rdata;
         buf_pc_q[wr_ptr_q]    <= mem_addr_q;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign pc_step   = pc_step_q;
   assign out_valid = (count_q != '0);
   assign out_instr = out_valid ? buf_instr_q[rd_ptr_q] : '0;
   assign out_pc    = out_valid ? buf_pc_q[rd_ptr_q]    : '0;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage directly downstream of the program-counter register. Takes the current PC and issues one instruction-memory read at a time over a req/ack handshake, and buffers returned instructions with their addresses in a small FIFO toward decode. Pulses `pc_step` to tell the next-PC logic to advance, and flushes all in-flight work on a branch `redirect`.

## Interface
- `ADDR_W`, 8, PC / instruction-memory address width
- `INSTR_W`, 16, instruction word width
- `DEPTH`, 2, prefetch buffer entries (power of two, ≥2)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pc`  in  ADDR_W  current PC (PC register output)
- `redirect`  in  1  one-cycle branch/jump flush pulse from execute
- `pc_step`  out  1  one-cycle pulse: next-PC logic selects pc+1 this cycle
- `mem_req`  out  1  instruction-memory read request
- `mem_addr`  out  ADDR_W  read address, stable while `mem_req`=1
- `mem_ack`  in  1  read data valid / request complete
- `mem_rdata`  in  INSTR_W  read data, sampled when `mem_ack`=1
- `out_valid`  out  1  head buffer entry valid
- `out_ready`  in  1  decode accepts head entry
- `out_instr`  out  INSTR_W  head instruction
- `out_pc`  out  ADDR_W  address of head instruction

## Operation
- FSM states IDLE, WAIT, STEP; at most one outstanding memory request.
- IDLE: if `count < DEPTH` and `redirect`=0 → latch `pc` into `mem_addr`, go WAIT; else stay.
- WAIT: `mem_req`=1, `mem_addr` held. On `mem_ack`=1: if `discard`=0 push {`mem_addr`, `mem_rdata`}; clear `discard`; go STEP. `mem_ack` while not in WAIT is ignored.
- STEP: `pc_step`=1 iff the completed response was pushed (not discarded); unconditionally return to IDLE next cycle. Next-PC logic gives `redirect` priority over `pc_step`.
- `redirect`=1 (any state): buffer count and pointers cleared that edge; flush overrides push and pop in the same cycle. In WAIT (and ack not same cycle) set `discard`; the request still completes, its data is dropped, and no `pc_step` follows. Redirect coinciding with ack in WAIT: data dropped, STEP produces no `pc_step`.
- Buffer: FIFO of `DEPTH`. Pop when `out_valid && out_ready`. Simultaneous push and pop allowed, count unchanged. Push never occurs when full (space reserved at issue).
- `out_valid` = (count ≠ 0); `out_instr`/`out_pc` show head entry, 0 when empty.
- Addresses wrap naturally (0xFF → 0x00 is handled upstream); tags are stored verbatim.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_addr`=0, `pc_step`=0, `out_valid`=0, `out_instr`=0, `out_pc`=0, count/pointers 0, `discard`=0.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- `mem_req` rises the cycle after IDLE sees space; earliest ack is in that first WAIT cycle.
- Pushed entry is visible at `out_valid` the cycle after the ack edge (the STEP cycle).
- `pc_step` is high exactly during STEP; the PC register captures pc+1 at the end of that cycle, so the new `pc` is seen in IDLE.
- Maximum throughput: one instruction per 3 cycles at zero-wait memory.
- Reset asserted mid-WAIT: all state cleared immediately; `mem_req` drops asynchronously; the memory must tolerate request abandonment.

## Test plan
- Reset, `pc`=0x00, ack in first WAIT cycle with rdata 0x1234, `out_ready`=1 → `mem_req` high 1 cycle, addr 0x00; `pc_step` 1 cycle; `out_valid` with instr 0x1234, pc 0x00; next request to 0x01.
- `out_ready`=0, zero-wait memory → two entries (0x00, 0x01) buffered, no `mem_req` while full with `pc`=0x02; one pop → request to 0x02 follows.
- Request to 0x05 in WAIT, `redirect` with target 0x40, ack 3 cycles later → buffer empty, no `pc_step`, data dropped, next `mem_addr`=0x40.
- Count 1 with push and pop in the same cycle → count stays 1, head becomes the new entry, order preserved.
- `pc` sequence 0xFE, 0xFF, 0x00 → `out_pc` tags 0xFE, 0xFF, 0x00 in order.
- `rst` asserted while in WAIT with 1 entry buffered → `mem_req`, `out_valid`, `pc_step` 0 immediately; fresh fetch resumes from current `pc` after release.
